// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX);
endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational winner select; MEM_ARB_RR_EN gives ties to the port that did not win last, else dbg wins.
module arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
  input  logic last,
`endif
  input  logic cpu_req,
  input  logic dbg_req,
  output logic win
);

  always_comb begin
    win = PORT_CPU;
    if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_RR_EN
      win = (last == PORT_DBG) ? PORT_CPU : PORT_DBG;
`else
      win = PORT_DBG;
`endif
    end else if (dbg_req) begin
      win = PORT_DBG;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// cpu/dbg share one memory port: gnt 1 cycle after sampling, rvalid RD_LAT+2 cycles after; one access in flight.
// Requesters hold req until gnt (no queueing); MEM_ARB_RR_EN selects round-robin ties, otherwise dbg wins.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              cpu_gnt,
  output logic              dbg_gnt,
  output logic              cpu_rvalid,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t           state, state_nxt;
  logic             win;
  logic             owner;
  logic             lat_we;
  logic [CNT_W-1:0] cnt;
  logic             any_req;

  assign any_req = cpu_req | dbg_req;

`ifdef MEM_ARB_RR_EN
  logic last;

  arb_pick u_pick (
    .last    (last),
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .win     (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= PORT_DBG;
    end else if (state == ACCESS) begin
      last <= owner;
    end
  end
`else
  arb_pick u_pick (
    .cpu_req (cpu_req),
    .dbg_req (dbg_req),
    .win     (win)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    cpu_gnt    = 1'b0;
    dbg_gnt    = 1'b0;
    cpu_rvalid = 1'b0;
    dbg_rvalid = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        cpu_gnt   = (owner == PORT_CPU);
        dbg_gnt   = (owner == PORT_DBG);
        state_nxt = lat_we ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
      end
      RESP: begin
        cpu_rvalid = (owner == PORT_CPU);
        dbg_rvalid = (owner == PORT_DBG);
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_addr/mem_wdata are the latched payload itself, so they hold between accesses.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= PORT_CPU;
      lat_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      cnt       <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner     <= win;
        lat_we    <= (win == PORT_DBG) ? dbg_we    : cpu_we;
        mem_addr  <= (win == PORT_DBG) ? dbg_addr  : cpu_addr;
        mem_wdata <= (win == PORT_DBG) ? dbg_wdata : cpu_wdata;
      end
      if (state == ACCESS) begin
        cnt <= CNT_W'(RD_LAT - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == WAIT && cnt == '0) begin
        rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RD_LAT=1 instance driven from a vector table with a grant/rvalid scoreboard,
// plus an RD_LAT=4 instance for long-latency read and reset-in-WAIT sequences.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RD_LAT=1 instance
  logic        c1_req = 0, c1_we = 0, d1_req = 0, d1_we = 0;
  logic [31:0] c1_addr = 0, c1_wdata = 0, d1_addr = 0, d1_wdata = 0;
  logic        c1_gnt, d1_gnt, c1_rv, d1_rv, men1, mwe1, busy1;
  logic [31:0] rdata1, maddr1, mwd1, mrd1;

  // RD_LAT=4 instance
  logic        c4_req = 0, c4_we = 0, d4_req = 0, d4_we = 0;
  logic [31:0] c4_addr = 0, c4_wdata = 0, d4_addr = 0, d4_wdata = 0;
  logic        c4_gnt, d4_gnt, c4_rv, d4_rv, men4, mwe4, busy4;
  logic [31:0] rdata4, maddr4, mwd4, mrd4;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
    .dbg_req(d1_req), .dbg_we(d1_we), .dbg_addr(d1_addr), .dbg_wdata(d1_wdata),
    .cpu_gnt(c1_gnt), .dbg_gnt(d1_gnt), .cpu_rvalid(c1_rv), .dbg_rvalid(d1_rv),
    .rdata(rdata1), .mem_en(men1), .mem_we(mwe1), .mem_addr(maddr1),
    .mem_wdata(mwd1), .mem_rdata(mrd1), .busy(busy1)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(4)) dut4 (
    .clk(clk), .rst(rst),
    .cpu_req(c4_req), .cpu_we(c4_we), .cpu_addr(c4_addr), .cpu_wdata(c4_wdata),
    .dbg_req(d4_req), .dbg_we(d4_we), .dbg_addr(d4_addr), .dbg_wdata(d4_wdata),
    .cpu_gnt(c4_gnt), .dbg_gnt(d4_gnt), .cpu_rvalid(c4_rv), .dbg_rvalid(d4_rv),
    .rdata(rdata4), .mem_en(men4), .mem_we(mwe4), .mem_addr(maddr4),
    .mem_wdata(mwd4), .mem_rdata(mrd4), .busy(busy4)
  );

  // Memory model: filler data when not reading exposes wrong capture timing.
  localparam logic [31:0] FILL = 32'hBAD0BAD0;
  logic [31:0] mem [256];
  logic [31:0] pipe1;
  logic [31:0] pipe4 [4];
  bit          mem_inited;

  function automatic logic [31:0] ival(input int i);
    if (i == 32'h20) return 32'h12345678;
    return {24'hA5A5A5, i[7:0]};
  endfunction

  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= ival(i);
      mem_inited <= 1'b1;
    end else if (men1 && mwe1) begin
      mem[maddr1[7:0]] <= mwd1;
    end
    pipe1    <= (men1 && !mwe1) ? mem[maddr1[7:0]] : FILL;
    pipe4[0] <= (men4 && !mwe4) ? mem[maddr4[7:0]] : FILL;
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign mrd1 = pipe1;
  assign mrd4 = pipe4[3];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard
  typedef struct { logic port; logic we; logic [31:0] addr; logic [31:0] wdata; } gexp_t;
  typedef struct { logic port; logic [31:0] data; } rexp_t;
  gexp_t gq[$];
  rexp_t rq[$];
  gexp_t g;
  rexp_t r;

  task automatic expect_txn(input logic port, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rd);
    gexp_t ge;
    rexp_t re;
    ge.port = port; ge.we = we; ge.addr = addr; ge.wdata = wdata;
    gq.push_back(ge);
    if (!we) begin
      re.port = port; re.data = rd;
      rq.push_back(re);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (c1_gnt && d1_gnt) chk("both_gnt", 2'b11, 2'b01);
      if (c1_rv && d1_rv)   chk("both_rvalid", 2'b11, 2'b01);
      if (men1 && !(c1_gnt || d1_gnt)) chk("mem_en_without_gnt", 1, 0);
      if (c1_gnt || d1_gnt) begin
        if (gq.size() == 0) begin
          chk("unexpected_gnt", {c1_gnt, d1_gnt}, 2'b00);
        end else begin
          g = gq.pop_front();
          chk("gnt_port", {c1_gnt, d1_gnt}, (g.port == PORT_DBG) ? 2'b01 : 2'b10);
          chk("gnt_mem_en", men1, 1);
          chk("gnt_mem_we", mwe1, g.we);
          chk("gnt_mem_addr", maddr1, g.addr);
          if (g.we) chk("gnt_mem_wdata", mwd1, g.wdata);
        end
      end
      if (c1_rv || d1_rv) begin
        if (rq.size() == 0) begin
          chk("unexpected_rvalid", {c1_rv, d1_rv}, 2'b00);
        end else begin
          r = rq.pop_front();
          chk("rvalid_port", {c1_rv, d1_rv}, (r.port == PORT_DBG) ? 2'b01 : 2'b10);
          chk("rdata", rdata1, r.data);
        end
      end
    end
  end

  // Vector table: inputs of both ports plus expected winner and read data.
  typedef struct {
    logic cr; logic cw; logic [31:0] ca; logic [31:0] cd;
    logic dr; logic dw; logic [31:0] da; logic [31:0] dd;
    logic xp; logic [31:0] xrd;
  } vec_t;
  vec_t vt[9];

  function automatic vec_t mk(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                              input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                              input logic xp, input logic [31:0] xrd);
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
    v.xp = xp; v.xrd = xrd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int   c0, t;
    logic we;
    @(negedge clk);
    c1_req = v.cr; c1_we = v.cw; c1_addr = v.ca; c1_wdata = v.cd;
    d1_req = v.dr; d1_we = v.dw; d1_addr = v.da; d1_wdata = v.dd;
    c0 = cyc;
    we = (v.xp == PORT_DBG) ? v.dw : v.cw;
    expect_txn(v.xp, we, (v.xp == PORT_DBG) ? v.da : v.ca,
               (v.xp == PORT_DBG) ? v.dd : v.cd, v.xrd);
    t = 0;
    do begin @(negedge clk); t++; end while (!(c1_gnt || d1_gnt) && t < 10);
    chk($sformatf("v%0d_gnt_cycle", idx), cyc - c0, 1);
    // The loser drops here too, before it can be sampled: its request is cancelled.
    c1_req = 0; d1_req = 0;
    if (!we) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!(c1_rv || d1_rv) && t < 10);
      chk($sformatf("v%0d_rvalid_cycle", idx), cyc - c0, 3);
    end
    t = 0;
    while (busy1 && t < 10) begin @(negedge clk); t++; end
    chk($sformatf("v%0d_idle_cycle", idx), cyc - c0, we ? 2 : 4);
  endtask

  initial begin
    int   c0, t, en_cnt, cpu_noise, bad;
    logic xp_seq [4];
    logic [31:0] xd_seq [4];

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy1, 0);
    chk("rst_gnt", {c1_gnt, d1_gnt}, 0);
    chk("rst_rvalid", {c1_rv, d1_rv}, 0);
    chk("rst_mem_en_we", {men1, mwe1}, 0);
    chk("rst_rdata", rdata1, 0);
    chk("rst_mem_addr", maddr1, 0);
    chk("rst_mem_wdata", mwd1, 0);
    chk("rst_busy4", busy4, 0);
    rst = 1'b0;

    vt[0] = mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, PORT_CPU, 0);
    vt[1] = mk(0, 0, 0, 0, 1, 0, 32'h20, 0, PORT_DBG, 32'h12345678);
    vt[2] = mk(1, 0, 32'h10, 0, 0, 0, 0, 0, PORT_CPU, 32'hDEADBEEF);
    vt[3] = mk(0, 0, 0, 0, 1, 1, 32'h44, 32'hCAFEF00D, PORT_DBG, 0);
`ifdef MEM_ARB_RR_EN
    vt[4] = mk(1, 1, 32'h50, 32'h11111111, 1, 1, 32'h54, 32'h22222222, PORT_CPU, 0);
    vt[6] = mk(1, 0, 32'h50, 0, 0, 0, 0, 0, PORT_CPU, 32'h11111111);
    vt[7] = mk(0, 0, 0, 0, 1, 0, 32'h54, 0, PORT_DBG, 32'hA5A5A554);
`else
    vt[4] = mk(1, 1, 32'h50, 32'h11111111, 1, 1, 32'h54, 32'h22222222, PORT_DBG, 0);
    vt[6] = mk(1, 0, 32'h50, 0, 0, 0, 0, 0, PORT_CPU, 32'hA5A5A550);
    vt[7] = mk(0, 0, 0, 0, 1, 0, 32'h54, 0, PORT_DBG, 32'h22222222);
`endif
    vt[5] = mk(1, 0, 32'h44, 0, 1, 0, 32'h10, 0, PORT_DBG, 32'hDEADBEEF);
    vt[8] = mk(1, 1, 32'h60, 32'h0BADF00D, 0, 0, 0, 0, PORT_CPU, 0);

    for (int i = 0; i < 9; i++) run_vec(vt[i], i);

    // After a write, rdata keeps the last read and the memory bus holds its address.
    repeat (2) @(negedge clk);
    chk("rdata_hold", rdata1, vt[7].xrd);
    chk("mem_addr_hold", maddr1, 32'h60);
    chk("mem_en_idle", {men1, mwe1}, 0);
    chk("sb_gq_empty", gq.size(), 0);
    chk("sb_rq_empty", rq.size(), 0);

    // Both ports reading continuously from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_ARB_RR_EN
    xp_seq = '{PORT_CPU, PORT_DBG, PORT_CPU, PORT_DBG};
    xd_seq = '{32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 32'h12345678};
`else
    xp_seq = '{PORT_DBG, PORT_DBG, PORT_DBG, PORT_DBG};
    xd_seq = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678};
`endif
    c1_req = 1; c1_we = 0; c1_addr = 32'h44;
    d1_req = 1; d1_we = 0; d1_addr = 32'h20;
    for (int k = 0; k < 4; k++)
      expect_txn(xp_seq[k], 1'b0, (xp_seq[k] == PORT_DBG) ? 32'h20 : 32'h44, 0, xd_seq[k]);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!(c1_gnt || d1_gnt) && t < 12);
      chk($sformatf("cont_gnt%0d_seen", k), (c1_gnt || d1_gnt), 1);
    end
    c1_req = 0; d1_req = 0;
    t = 0;
    while (busy1 && t < 12) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk("cont_gq_empty", gq.size(), 0);
    chk("cont_rq_empty", rq.size(), 0);

    // RD_LAT=4 read
    @(negedge clk);
    d4_req = 1; d4_we = 0; d4_addr = 32'h20;
    c0 = cyc; en_cnt = 0; cpu_noise = 0; t = 0;
    do begin
      @(negedge clk); t++;
      if (men4) en_cnt++;
      if (c4_gnt || c4_rv) cpu_noise++;
      if (d4_gnt) d4_req = 0;
    end while (!d4_rv && t < 16);
    chk("lat4_rvalid_cycle", cyc - c0, 6);
    chk("lat4_mem_en_cycles", en_cnt, 1);
    chk("lat4_rdata", rdata4, 32'h12345678);
    chk("lat4_cpu_silent", cpu_noise, 0);
    d4_req = 0;
    repeat (2) @(negedge clk);

    // Reset raised while dut4 sits in WAIT
    d4_req = 1; d4_we = 0; d4_addr = 32'h10;
    c0 = cyc;
    @(negedge clk);
    chk("rstwait_gnt", d4_gnt, 1);
    d4_req = 0;
    @(negedge clk);
    chk("rstwait_busy_before", busy4, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstwait_busy_after", busy4, 0);
    chk("rstwait_rdata_cleared", rdata4, 0);
    chk("rstwait_rvalid", {c4_rv, d4_rv}, 0);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (c4_rv || d4_rv || busy4 || men4) bad++;
    end
    chk("rstwait_no_late_activity", bad, 0);
    chk("rstwait_rdata_ignored", rdata4, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ADDR_W, 32, address width.
  DATA_W, 32, data width.
  RD_LAT, 1, memory read latency in cycles, legal range 1..4.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  sole clock; all logic on its rising edge.
  rst  in  1  reset; synchronous, active-high.
  cpu_req/dbg_req  in  1  access request from the CPU controller or the debug/loader port.
  cpu_we/dbg_we  in  1  1 = write, 0 = read.
  cpu_addr/dbg_addr  in  ADDR_W  access address.
  cpu_wdata/dbg_wdata  in  DATA_W  write data.
  cpu_gnt/dbg_gnt  out  1  one-cycle grant pulse.
  cpu_rvalid/dbg_rvalid  out  1  one-cycle read-data-valid pulse.
  rdata  out  DATA_W  registered read data, shared by both ports.
  mem_en, mem_we  out  1  memory strobe and write enable.
  mem_addr  out  ADDR_W  memory address.
  mem_wdata  out  DATA_W  memory write data.
  mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after mem_en.
  busy  out  1  high whenever state != IDLE.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, ACCESS, WAIT, RESP.
REQ-004 Requests SHALL be sampled only in IDLE; a request raised in any other state is held by the requester and sampled on the next IDLE cycle.
REQ-005 In IDLE with any req high, the block SHALL latch the winner's we/addr/wdata and record the winner ID, then go to ACCESS.
REQ-006 In ACCESS the block SHALL assert mem_en for exactly one cycle, drive mem_we/mem_addr/mem_wdata from the latched values, and pulse the winner's gnt in that same cycle.
REQ-007 Write transactions SHALL leave ACCESS and return to IDLE, so a request sampled at cycle N is granted at N+1 and the next request can be sampled at N+2.
REQ-008 Read transactions SHALL pass from ACCESS to WAIT and hold there until RD_LAT cycles after mem_en, then capture mem_rdata into rdata and enter RESP.
REQ-009 In RESP the block SHALL pulse the winner's rvalid for one cycle, then return to IDLE; read rvalid therefore falls at N+2+RD_LAT.
REQ-010 The non-winner's gnt and rvalid SHALL stay low for the whole transaction.
REQ-011 Outside ACCESS, mem_en and mem_we SHALL be 0, while mem_addr and mem_wdata hold their last value.
REQ-012 rdata SHALL hold its value until the next read capture.
REQ-013 A requester SHALL keep req and its payload stable until gnt; dropping req before it is sampled SHALL cancel the request with no memory access.
REQ-014 Dropping req after gnt SHALL NOT abort an in-flight read; its rvalid is still delivered.
REQ-015 When cpu_req and dbg_req are sampled high in the same IDLE cycle, arbitration SHALL follow REQ-019.

Reset
REQ-016 While rst is high at a clock edge, the block SHALL set state=IDLE and drive gnt, rvalid, mem_en, mem_we and busy to 0.
REQ-017 The same reset SHALL clear rdata, mem_addr and mem_wdata to 0 and set the round-robin pointer to "dbg last".
REQ-018 Reset asserted mid-transaction SHALL abort it: a pending rvalid is never issued and a late mem_rdata is ignored.

Configuration
REQ-019 With MEM_ARB_RR_EN defined, ties SHALL be resolved round-robin: the port that did not win the last grant wins, and the pointer updates on every grant.
REQ-020 Without MEM_ARB_RR_EN, ties SHALL be fixed-priority, with dbg always winning; no pointer register is built.

Structure
REQ-021 A shared package mem_arb_pkg SHALL hold the state enumeration, the port-ID constants (PORT_CPU=0, PORT_DBG=1) and the RD_LAT bounds.
REQ-022 One sub-module, arb_pick, SHALL select the winner combinationally from both req signals and the pointer; everything else lives in mem_arbiter.

Verification
REQ-023 The bench SHALL cover these directed scenarios (RD_LAT=1 unless stated):
  CPU write, req at cycle 0, addr 0x10, data 0xDEADBEEF -> cpu_gnt and mem_en/mem_we at cycle 1; busy low at cycle 2.
  dbg read of 0x20, memory returns 0x12345678 -> dbg_gnt at cycle 1, dbg_rvalid at cycle 3, rdata = 0x12345678; cpu signals stay silent.
  Both ports continuously requesting reads -> RR build grants cpu, dbg, cpu, dbg in alternation; fixed build grants dbg every transaction.
  RD_LAT=4 read -> rvalid exactly 6 cycles after req is sampled; mem_en high for exactly 1 cycle.
  rst raised in WAIT -> next cycle state IDLE, no rvalid ever issued, busy 0.
